// File: rtl/cond_entradas.sv
// Input conditioning: two-flop sync, per-channel debounce, press/release
// pulses and optional button auto-repeat for the countdown timer.
module cond_entradas #(
    parameter int N_BTN           = 2,
    parameter int N_SW            = 7,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    input  logic [N_SW-1:0]  sw_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_press,
    output logic [N_BTN-1:0] btn_release,
    output logic [N_SW-1:0]  sw_stable,
    output logic             sw_changed
);

    localparam int N = N_BTN + N_SW;
    localparam logic [23:0] DB = 24'(DEBOUNCE_CYCLES);

    typedef enum logic {ST_STABLE, ST_PENDING} st_t;

    logic [N-1:0] w_raw;
    logic [N-1:0] r_s0;
    logic [N-1:0] r_s1;
    logic [N-1:0] r_lvl;
    st_t          r_st  [N];
    logic [23:0]  r_cnt [N];
    logic [23:0]  w_smp [N];
    logic [N-1:0] w_flip;
    logic [N_BTN-1:0] w_rep;
    logic [N_BTN-1:0] r_press;
    logic [N_BTN-1:0] r_rel;
    logic             r_chg;

    assign w_raw = {sw_raw, btn_raw};

    // w_smp counts consecutive differing samples including the current one
    always_comb begin
        w_flip = '0;
        for (int i = 0; i < N; i++) begin
            w_smp[i] = 24'd1;
            if (r_st[i] == ST_PENDING)
                w_smp[i] = (r_cnt[i] == 24'hFFFFFF) ? r_cnt[i] : r_cnt[i] + 24'd1;
            w_flip[i] = (r_s1[i] != r_lvl[i]) && (w_smp[i] >= DB);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s0    <= '0;
            r_s1    <= '0;
            r_lvl   <= '0;
            r_press <= '0;
            r_rel   <= '0;
            r_chg   <= 1'b0;
            for (int i = 0; i < N; i++) begin
                r_st[i]  <= ST_STABLE;
                r_cnt[i] <= '0;
            end
        end else begin
            r_s0    <= w_raw;
            r_s1    <= r_s0;
            r_lvl   <= r_lvl ^ w_flip;
            r_press <= (w_flip[N_BTN-1:0] & ~r_lvl[N_BTN-1:0]) | w_rep;
            r_rel   <= w_flip[N_BTN-1:0] & r_lvl[N_BTN-1:0];
            r_chg   <= |w_flip[N-1:N_BTN];
            for (int i = 0; i < N; i++) begin
                if (r_s1[i] == r_lvl[i] || w_flip[i]) begin
                    r_st[i]  <= ST_STABLE;
                    r_cnt[i] <= '0;
                end else begin
                    r_st[i]  <= ST_PENDING;
                    r_cnt[i] <= w_smp[i];
                end
            end
        end
    end

    generate
        if (REPEAT_CYCLES > 0) begin : g_rep
            localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES + 1) : 1;
            localparam logic [RW-1:0] RLAST = RW'(REPEAT_CYCLES - 1);

            logic [RW-1:0]    r_rcnt [N_BTN];
            logic [N_BTN-1:0] w_hold;

            // only repeat while the level stays high through this edge
            always_comb begin
                w_hold = r_lvl[N_BTN-1:0] & ~w_flip[N_BTN-1:0];
                w_rep  = '0;
                for (int b = 0; b < N_BTN; b++)
                    w_rep[b] = w_hold[b] && (r_rcnt[b] == RLAST);
            end

            always_ff @(posedge clock) begin
                for (int b = 0; b < N_BTN; b++) begin
                    if (reset || !w_hold[b] || r_rcnt[b] == RLAST)
                        r_rcnt[b] <= '0;
                    else
                        r_rcnt[b] <= r_rcnt[b] + RW'(1);
                end
            end
        end else begin : g_norep
            assign w_rep = '0;
        end
    endgenerate

    assign btn_level   = r_lvl[N_BTN-1:0];
    assign sw_stable   = r_lvl[N-1:N_BTN];
    assign btn_press   = r_press;
    assign btn_release = r_rel;
    assign sw_changed  = r_chg;

endmodule

// File: tb/tb_cond_entradas.sv
// Scoreboard bench for cond_entradas: two instances (plain debounce and
// auto-repeat), expected pulse events queued by stimulus, checked by monitor.
module tb_cond_entradas;

    typedef struct packed {
        int         cyc;
        logic [1:0] pr;
        logic [1:0] rl;
        logic       ch;
        logic [1:0] lv;
        logic [6:0] sw;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] btn_a, btn_b;
    logic [6:0] sw_a, sw_b;
    logic [1:0] lv_a, pr_a, rl_a, lv_b, pr_b, rl_b;
    logic [6:0] st_a, st_b;
    logic       ch_a, ch_b;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_fail = 0;
    ev_t  qa[$];
    ev_t  qb[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    cond_entradas #(.N_BTN(2), .N_SW(7), .DEBOUNCE_CYCLES(4), .REPEAT_CYCLES(0)) u_a (
        .clock(clk), .reset(rst), .btn_raw(btn_a), .sw_raw(sw_a),
        .btn_level(lv_a), .btn_press(pr_a), .btn_release(rl_a),
        .sw_stable(st_a), .sw_changed(ch_a));

    cond_entradas #(.N_BTN(2), .N_SW(7), .DEBOUNCE_CYCLES(2), .REPEAT_CYCLES(5)) u_b (
        .clock(clk), .reset(rst), .btn_raw(btn_b), .sw_raw(sw_b),
        .btn_level(lv_b), .btn_press(pr_b), .btn_release(rl_b),
        .sw_stable(st_b), .sw_changed(ch_b));

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, got, exp, cyc);
        end
    endtask

    function automatic ev_t mk(input int c, input logic [1:0] pr, input logic [1:0] rl,
                               input logic ch, input logic [1:0] lv, input logic [6:0] sw);
        ev_t e;
        e.cyc = c; e.pr = pr; e.rl = rl; e.ch = ch; e.lv = lv; e.sw = sw;
        return e;
    endfunction

    task automatic mon(input int id, input ev_t got, input logic act);
        ev_t e;
        int  sz;
        sz = (id == 0) ? qa.size() : qb.size();
        if (act) begin
            n_chk++;
            if (sz == 0) begin
                n_fail++;
                $display("FAIL dut%0d unexpected: cyc=%0d pr=%b rl=%b ch=%b lv=%b sw=%b",
                         id, got.cyc, got.pr, got.rl, got.ch, got.lv, got.sw);
            end else begin
                e = (id == 0) ? qa.pop_front() : qb.pop_front();
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL dut%0d event: got cyc=%0d pr=%b rl=%b ch=%b lv=%b sw=%b required cyc=%0d pr=%b rl=%b ch=%b lv=%b sw=%b",
                             id, got.cyc, got.pr, got.rl, got.ch, got.lv, got.sw,
                             e.cyc, e.pr, e.rl, e.ch, e.lv, e.sw);
                end
            end
        end else if (sz != 0) begin
            e = (id == 0) ? qa[0] : qb[0];
            if (e.cyc < got.cyc) begin
                n_chk++;
                n_fail++;
                $display("FAIL dut%0d missed: got no pulse required event at cyc=%0d", id, e.cyc);
                if (id == 0) void'(qa.pop_front());
                else void'(qb.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, mk(cyc, pr_a, rl_a, ch_a, lv_a, st_a), (|pr_a) || (|rl_a) || ch_a);
        mon(1, mk(cyc, pr_b, rl_b, ch_b, lv_b, st_b), (|pr_b) || (|rl_b) || ch_b);
    end

    task automatic chk_zero(input string nm);
        chk({nm, "_a"}, {23'd0, lv_a, pr_a, rl_a, st_a, ch_a}, 32'd0);
        chk({nm, "_b"}, {23'd0, lv_b, pr_b, rl_b, st_b, ch_b}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; btn_a = 2'b11; sw_a = '0; btn_b = '0; sw_b = '0;
        tick(1);
        chk_zero("rst_e1");
        tick(2);
        chk_zero("rst_e3");
        rst = 1'b0;
        qa.push_back(mk(cyc + 6, 2'b11, 2'b00, 1'b0, 2'b11, 7'd0));
        tick(1);
        chk_zero("post_rst");
        tick(8);
        chk("lvl_both", 32'(lv_a), 32'h3);

        btn_a = 2'b00;
        qa.push_back(mk(cyc + 6, 2'b00, 2'b11, 1'b0, 2'b00, 7'd0));
        tick(10);

        btn_a = 2'b01;
        qa.push_back(mk(cyc + 6, 2'b01, 2'b00, 1'b0, 2'b01, 7'd0));
        tick(10);
        chk("lvl_b0", 32'(lv_a), 32'h1);
        btn_a = 2'b00;
        qa.push_back(mk(cyc + 6, 2'b00, 2'b01, 1'b0, 2'b00, 7'd0));
        tick(10);

        btn_a = 2'b01; tick(1);
        btn_a = 2'b00; tick(1);
        btn_a = 2'b01; tick(1);
        btn_a = 2'b00; tick(1);
        btn_a = 2'b01;
        qa.push_back(mk(cyc + 6, 2'b01, 2'b00, 1'b0, 2'b01, 7'd0));
        tick(10);
        btn_a = 2'b00;
        qa.push_back(mk(cyc + 6, 2'b00, 2'b01, 1'b0, 2'b00, 7'd0));
        tick(10);

        sw_a = 7'b0101101;
        qa.push_back(mk(cyc + 6, 2'b00, 2'b00, 1'b1, 2'b00, 7'b0101101));
        tick(10);
        chk("sw_stable", 32'(st_a), 32'h2D);

        sw_a = 7'b0101111; btn_a = 2'b10;
        tick(3);
        sw_a = 7'b0101101; btn_a = 2'b00;
        tick(10);
        chk("glitch_sw", 32'(st_a), 32'h2D);
        chk("glitch_btn", 32'(lv_a), 32'h0);

        btn_a = 2'b01;
        tick(2);
        rst = 1'b1;
        tick(1);
        chk_zero("mid_rst");
        rst = 1'b0;
        qa.push_back(mk(cyc + 6, 2'b01, 2'b00, 1'b1, 2'b01, 7'b0101101));
        tick(12);
        chk("lvl_after_rst", 32'(lv_a), 32'h1);

        btn_b = 2'b10;
        for (int r = 0; r < 4; r++)
            qb.push_back(mk(cyc + 4 + 5 * r, 2'b10, 2'b00, 1'b0, 2'b10, 7'd0));
        tick(20);
        btn_b = 2'b00;
        qb.push_back(mk(cyc + 4, 2'b00, 2'b10, 1'b0, 2'b00, 7'd0));
        tick(14);
        chk("rep_lvl", 32'(lv_b), 32'h0);

        chk("qa_empty", 32'(qa.size()), 32'd0);
        chk("qb_empty", 32'(qb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
